// File: rtl/bram_pkg.sv
// Shared types and constants for the BRAM client front end and its response queue.
package bram_pkg;

    localparam int BRAM_ADDR_WIDTH     = 10;
    localparam int BRAM_DATA_WIDTH     = 32;
    localparam int BRAM_BYTES_PER_WORD = BRAM_DATA_WIDTH / 8;

    localparam int RESP_DEPTH       = 2;
    localparam int RESP_COUNT_WIDTH = $clog2(RESP_DEPTH + 1);

    typedef logic [BRAM_ADDR_WIDTH-1:0]     addr_t;
    typedef logic [BRAM_BYTES_PER_WORD-1:0] strobe_t;
    typedef logic [BRAM_DATA_WIDTH-1:0]     word_t;
    typedef logic [RESP_COUNT_WIDTH-1:0]    resp_count_t;

    typedef struct packed {
        word_t data;
        logic  write;
    } resp_entry_t;

endpackage

// File: rtl/bram_resp_fifo.sv
// Two-entry response queue holding read/write results that the consumer has not yet taken.
module bram_resp_fifo
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = BRAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_write,
    input  logic                  pop,
    output resp_count_t           count,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_write
);

    logic [DATA_WIDTH-1:0] mem_data  [RESP_DEPTH];
    logic                  mem_write [RESP_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;

    // Pointers are a single bit each, so they wrap naturally at the depth of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                mem_data[i]  <= '0;
                mem_write[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr]  <= push_data;
                mem_write[wr_ptr] <= push_write;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + resp_count_t'(1);
                2'b01:   count <= count - resp_count_t'(1);
                default: count <= count;
            endcase
        end
    end

    assign empty      = (count == '0);
    assign head_data  = mem_data[rd_ptr];
    assign head_write = mem_write[rd_ptr];

endmodule

// File: rtl/bram_client.sv
// Initiator front end for one BRAM port: issues word requests, hides the one-cycle read
// latency and returns in-order responses over a back-pressured channel.
module bram_client
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH     = BRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = BRAM_DATA_WIDTH,
    parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [BYTES_PER_WORD-1:0] req_strobe,
    input  logic [DATA_WIDTH-1:0]     req_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic                      resp_write,
    output logic                      bram_en,
    output logic [BYTES_PER_WORD-1:0] bram_write_en,
    output logic [ADDR_WIDTH-1:0]     bram_addr,
    output logic [DATA_WIDTH-1:0]     bram_data_in,
    input  logic [DATA_WIDTH-1:0]     bram_data_out
);

    logic                  fire;
    logic                  inflight;
    logic                  inflight_write;
    logic                  warmup;
    resp_count_t           fifo_count;
    resp_count_t           occupancy;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_write;
    logic                  push;
    logic                  pop;

    // Acceptance depends only on registered state, so resp_ready never reaches req_ready.
    assign occupancy = fifo_count + resp_count_t'(inflight);
    assign req_ready = !warmup && (occupancy < resp_count_t'(RESP_DEPTH));
    assign fire      = req_valid && req_ready;

    assign bram_en       = fire;
    assign bram_write_en = fire ? req_strobe : '0;
    assign bram_addr     = req_addr;
    assign bram_data_in  = req_data;

    // Warmup masks the first cycle after reset release while the BRAM output register settles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warmup         <= 1'b1;
            inflight       <= 1'b0;
            inflight_write <= 1'b0;
        end else begin
            warmup         <= 1'b0;
            inflight       <= fire;
            inflight_write <= fire && (req_strobe != '0);
        end
    end

    // Older queued responses take priority; otherwise fresh BRAM data bypasses the queue.
    always_comb begin
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_write = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        if (!fifo_empty) begin
            resp_valid = 1'b1;
            resp_data  = head_data;
            resp_write = head_write;
            pop        = resp_ready;
            push       = inflight;
        end else if (inflight) begin
            resp_valid = 1'b1;
            resp_data  = bram_data_out;
            resp_write = inflight_write;
            push       = !resp_ready;
        end
    end

    bram_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (bram_data_out),
        .push_write (inflight_write),
        .pop        (pop),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .head_data  (head_data),
        .head_write (head_write)
    );

endmodule

// File: tb/tb_bram_client.sv
// Self-checking bench for bram_client: a write-first BRAM model on the port side and a
// reference memory plus expected-response queue on the consumer side.
module tb_bram_client;
    import bram_pkg::*;

    localparam int MEM_WORDS = 1 << BRAM_ADDR_WIDTH;

    logic    clk = 1'b0;
    logic    reset;
    logic    req_valid;
    logic    req_ready;
    addr_t   req_addr;
    strobe_t req_strobe;
    word_t   req_data;
    logic    resp_valid;
    logic    resp_ready;
    word_t   resp_data;
    logic    resp_write;
    logic    bram_en;
    strobe_t bram_write_en;
    addr_t   bram_addr;
    word_t   bram_data_in;
    word_t   bram_data_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bram_client #(
        .ADDR_WIDTH (BRAM_ADDR_WIDTH),
        .DATA_WIDTH (BRAM_DATA_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_strobe    (req_strobe),
        .req_data      (req_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_write    (resp_write),
        .bram_en       (bram_en),
        .bram_write_en (bram_write_en),
        .bram_addr     (bram_addr),
        .bram_data_in  (bram_data_in),
        .bram_data_out (bram_data_out)
    );

    function automatic word_t init_word(input int i);
        return word_t'((i + 1) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Write-first BRAM with a registered output that is cleared by reset; contents survive reset.
    word_t bram_mem [MEM_WORDS];
    logic  mem_loaded = 1'b0;

    function automatic word_t bram_merge(input word_t old, input word_t din, input strobe_t we);
        word_t w;
        w = old;
        for (int b = 0; b < BRAM_BYTES_PER_WORD; b++)
            if (we[b]) w[8*b +: 8] = din[8*b +: 8];
        return w;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bram_data_out <= '0;
            if (!mem_loaded) begin
                for (int i = 0; i < MEM_WORDS; i++) bram_mem[i] <= init_word(i);
                mem_loaded <= 1'b1;
            end
        end else if (bram_en) begin
            bram_mem[bram_addr] <= bram_merge(bram_mem[bram_addr], bram_data_in, bram_write_en);
            bram_data_out       <= bram_merge(bram_mem[bram_addr], bram_data_in, bram_write_en);
        end
    end

    // Reference: memory image updated at acceptance, expected responses in acceptance order.
    word_t       ref_mem [MEM_WORDS];
    resp_entry_t exp_q [$];

    task automatic model_accept(input addr_t a, input strobe_t s, input word_t d);
        word_t mask;
        mask = '0;
        for (int b = 0; b < BRAM_BYTES_PER_WORD; b++)
            mask = mask | (word_t'({8{s[b]}}) << (8 * b));
        ref_mem[a] = (ref_mem[a] & ~mask) | (d & mask);
        exp_q.push_back('{data: ref_mem[a], write: (s != '0)});
    endtask

    logic        s_ready, s_rvalid, s_rwrite, s_fire, s_rfire, s_ben;
    word_t       s_rdata;
    strobe_t     s_bwe;
    int          s_outstanding;
    resp_entry_t exp_e;

    // One clock cycle: drive at posedge+1, sample at negedge, feed the model on acceptance.
    task automatic drive_cycle(input logic v, input addr_t a, input strobe_t s, input word_t d,
                               input logic rr);
        req_valid  = v;
        req_addr   = a;
        req_strobe = s;
        req_data   = d;
        resp_ready = rr;
        @(negedge clk);
        s_ready       = req_ready;
        s_rvalid      = resp_valid;
        s_rdata       = resp_data;
        s_rwrite      = resp_write;
        s_ben         = bram_en;
        s_bwe         = bram_write_en;
        s_fire        = v && req_ready;
        s_rfire       = resp_valid && rr;
        s_outstanding = exp_q.size();
        if (s_fire) model_accept(a, s, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b, required 0", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_valid: got %b, required 0", resp_valid); end
        n_cmp++; if (resp_data !== '0) begin n_fail++; $display("[TB] FAIL reset_resp_data: got %h, required 0", resp_data); end
        n_cmp++; if (resp_write !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_write: got %b, required 0", resp_write); end
        n_cmp++; if (bram_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bram_en: got %b, required 0", bram_en); end
        n_cmp++; if (bram_write_en !== '0) begin n_fail++; $display("[TB] FAIL reset_bram_we: got %h, required 0", bram_write_en); end
        @(posedge clk);
        #1 reset = 1'b0;
        drive_cycle(1'b0, '0, '0, '0, 1'b1);
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL warmup_ready: got %b, required 0", s_ready); end
        drive_cycle(1'b0, '0, '0, '0, 1'b1);
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_warmup_ready: got %b, required 1", s_ready); end
    endtask

    task automatic test_write_read();
        drive_cycle(1'b1, 10'h005, 4'hF, 32'hCAFE_BABE, 1'b1);
        n_cmp++; if (s_fire !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_accept: got %b, required 1", s_fire); end
        n_cmp++; if (s_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_early_resp: got %b, required 0", s_rvalid); end
        drive_cycle(1'b1, 10'h005, 4'h0, 32'h0, 1'b1);
        n_cmp++; if (s_fire !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_accept: got %b, required 1", s_fire); end
        n_cmp++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFE_BABE || s_rwrite !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wr_resp: got v=%b d=%h w=%b, required v=1 d=cafebabe w=1", s_rvalid, s_rdata, s_rwrite);
        end
        drive_cycle(1'b0, '0, '0, '0, 1'b1);
        n_cmp++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFE_BABE || s_rwrite !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rd_resp: got v=%b d=%h w=%b, required v=1 d=cafebabe w=0", s_rvalid, s_rdata, s_rwrite);
        end
        drive_cycle(1'b0, '0, '0, '0, 1'b1);
        n_cmp++; if (s_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_rd_idle: got %b, required 0", s_rvalid); end
        exp_q.delete();
    endtask

    task automatic test_partial_write();
        drive_cycle(1'b1, 10'h005, 4'b0011, 32'h0000_1234, 1'b1);
        drive_cycle(1'b1, 10'h005, 4'h0, 32'h0, 1'b1);
        n_cmp++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFE_1234 || s_rwrite !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL partial_wr_resp: got v=%b d=%h w=%b, required v=1 d=cafe1234 w=1", s_rvalid, s_rdata, s_rwrite);
        end
        drive_cycle(1'b0, '0, '0, '0, 1'b1);
        n_cmp++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFE_1234 || s_rwrite !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL partial_rd_resp: got v=%b d=%h w=%b, required v=1 d=cafe1234 w=0", s_rvalid, s_rdata, s_rwrite);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            drive_cycle(i < 8, addr_t'(i + 1), '0, '0, 1'b1);
            if (i < 8) begin
                n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready[%0d]: got %b, required 1", i, s_ready); end
            end
            n_cmp++;
            if (s_rvalid !== (i > 0)) begin
                n_fail++;
                $display("[TB] FAIL b2b_resp_valid[%0d]: got %b, required %b", i, s_rvalid, (i > 0));
            end
            if (s_rfire) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL b2b_extra_resp: got %h, required none", s_rdata);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (s_rdata !== exp_e.data || s_rwrite !== exp_e.write) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_resp[%0d]: got %h/%b, required %h/%b", i, s_rdata, s_rwrite, exp_e.data, exp_e.write);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int issued;
        int fires;
        issued = 0;
        fires  = 0;
        for (int c = 0; c < 4; c++) begin
            drive_cycle(1'b1, addr_t'(10'h010 + issued), '0, '0, 1'b0);
            if (s_fire) begin issued++; fires++; end
        end
        n_cmp++; if (fires !== 2) begin n_fail++; $display("[TB] FAIL bp_accept_count: got %0d, required 2", fires); end
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_low: got %b, required 0", s_ready); end
        for (int c = 0; c < 12 && (issued < 4 || exp_q.size() != 0); c++) begin
            drive_cycle(issued < 4, addr_t'(10'h010 + issued), '0, '0, 1'b1);
            if (s_fire) issued++;
            if (c == 0) begin
                n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_pop_cycle: got %b, required 0", s_ready); end
            end
            if (c == 1) begin
                n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_after_pop: got %b, required 1", s_ready); end
            end
            if (s_rfire) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL bp_extra_resp: got %h, required none", s_rdata);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (s_rdata !== exp_e.data || s_rwrite !== exp_e.write) begin
                        n_fail++;
                        $display("[TB] FAIL bp_resp: got %h/%b, required %h/%b", s_rdata, s_rwrite, exp_e.data, exp_e.write);
                    end
                end
            end
        end
        n_cmp++;
        if (issued !== 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL bp_drain: got issued=%0d pending=%0d, required issued=4 pending=0", issued, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        word_t w0;
        word_t w1;
        w0 = $urandom;
        w1 = $urandom;
        drive_cycle(1'b1, 10'h020, 4'hF, w0, 1'b0);
        drive_cycle(1'b1, 10'h021, 4'hF, w1, 1'b0);
        drive_cycle(1'b0, '0, '0, '0, 1'b0);
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_full_ready: got %b, required 0", s_ready); end
        reset = 1'b1;
        #2;
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_valid: got %b, required 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_ready: got %b, required 0", req_ready); end
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        drive_cycle(1'b0, '0, '0, '0, 1'b1);
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_warmup_ready: got %b, required 0", s_ready); end
        drive_cycle(1'b1, 10'h020, '0, '0, 1'b1);
        n_cmp++; if (s_fire !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_read_accept: got %b, required 1", s_fire); end
        drive_cycle(1'b0, '0, '0, '0, 1'b1);
        n_cmp++;
        if (s_rvalid !== 1'b1 || s_rdata !== w0 || s_rwrite !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_read_resp: got v=%b d=%h w=%b, required v=1 d=%h w=0", s_rvalid, s_rdata, s_rwrite, w0);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic    p;
        addr_t   pa;
        strobe_t ps;
        word_t   pd;
        logic    rr;
        p  = 1'b0;
        pa = '0;
        ps = '0;
        pd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!p && $urandom_range(0, 3) != 0) begin
                p  = 1'b1;
                pa = 10'h040 | addr_t'($urandom_range(0, 7));
                ps = ($urandom_range(0, 1) == 0) ? strobe_t'(0) : strobe_t'($urandom);
                pd = $urandom;
            end
            rr = ($urandom_range(0, 9) < 7);
            drive_cycle(p, pa, ps, pd, rr);
            n_cmp++;
            if (s_ready !== (s_outstanding < 2) || s_rvalid !== (s_outstanding > 0)) begin
                n_fail++;
                $display("[TB] FAIL rnd_flow[%0d]: got ready=%b valid=%b, required ready=%b valid=%b", c, s_ready, s_rvalid, (s_outstanding < 2), (s_outstanding > 0));
            end
            n_cmp++;
            if (s_ben !== s_fire || s_bwe !== (s_fire ? ps : strobe_t'(0))) begin
                n_fail++;
                $display("[TB] FAIL rnd_bram_port[%0d]: got en=%b we=%h, required en=%b we=%h", c, s_ben, s_bwe, s_fire, (s_fire ? ps : strobe_t'(0)));
            end
            if (s_fire) p = 1'b0;
            if (s_rfire) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL rnd_extra_resp: got %h, required none", s_rdata);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (s_rdata !== exp_e.data || s_rwrite !== exp_e.write) begin
                        n_fail++;
                        $display("[TB] FAIL rnd_resp[%0d]: got %h/%b, required %h/%b", c, s_rdata, s_rwrite, exp_e.data, exp_e.write);
                    end
                end
            end
        end
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            drive_cycle(1'b0, '0, '0, '0, 1'b1);
            if (s_rfire) begin
                n_cmp++;
                exp_e = exp_q.pop_front();
                if (s_rdata !== exp_e.data || s_rwrite !== exp_e.write) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_drain_resp: got %h/%b, required %h/%b", s_rdata, s_rwrite, exp_e.data, exp_e.write);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL rnd_lost_resp: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        req_valid  = 1'b0;
        req_addr   = '0;
        req_strobe = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
